// File: rtl/tdc_pkg.sv
// Shared types, constants and encoding helpers for the TDC readout path.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    START,
    DATA,
    STOP
  } readout_state_t;

  localparam int UART_FRAME_BITS      = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int MAX_STAGES           = 127;

  function automatic logic [6:0] popcount(
    input logic [MAX_STAGES-1:0] v
  );
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

  // Valid codes are 2^k-1, so adding one never overlaps a set bit.
  function automatic logic is_thermometer(
    input logic [MAX_STAGES-1:0] v
  );
    return (v & (v + MAX_STAGES'(1))) == '0;
  endfunction

endpackage

// File: rtl/tdc_readout_if.sv
// Host-facing bundle of the TDC readout block.
interface tdc_readout_if #(
  parameter int NUM_STAGES = 10
);
  logic [NUM_STAGES-1:0] stage_delays;
  logic                  sample_req;
  logic                  uart_tx;
  logic                  busy;
  logic [7:0]            result;
  logic                  result_valid;
  logic                  overrun;

  modport master (
    output stage_delays, sample_req,
    input  uart_tx, busy, result,
    input  result_valid, overrun
  );

  modport slave (
    input  stage_delays, sample_req,
    output uart_tx, busy, result,
    output result_valid, overrun
  );
endinterface

// File: rtl/tdc_readout_uart_tx.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit.
module tdc_uart_tx
  import tdc_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  readout_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     data_q, data_d;
  logic           tx_q, tx_d;
  logic           wrap;

  assign wrap   = baud_q == BW'(CLKS_PER_BIT - 1);
  assign tx_o   = tx_q;
  assign busy_o = state_q != IDLE;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = wrap ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (start_i) begin
          data_d  = data_i;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (wrap) begin
          tx_d    = data_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/tdc_readout.sv
// Captures a TDC thermometer snapshot, encodes it and ships it over UART.
module tdc_readout
  import tdc_pkg::*;
#(
  parameter int NUM_STAGES   = 10,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input logic          clk,
  input logic          reset_n,
  tdc_readout_if.slave bus
);

  readout_state_t        state_q, state_d;
  logic [NUM_STAGES-1:0] cap_q, cap_d;
  logic [7:0]            result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic                  start;
  logic                  tx_busy;
  logic [7:0]            enc;
  logic [MAX_STAGES-1:0] cap_pad;

  assign cap_pad = MAX_STAGES'(cap_q);
  assign enc     = {~is_thermometer(cap_pad),
                    popcount(cap_pad)};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cap_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  // The serializer's busy stands in for the START/DATA/STOP states.
  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    result_d = result_q;
    valid_d  = 1'b0;
    start    = 1'b0;
    ovr_d    = bus.sample_req &&
               (state_q != IDLE || tx_busy);
    unique case (state_q)
      IDLE: begin
        if (bus.sample_req && !tx_busy) begin
          cap_d   = bus.stage_delays;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        result_d = enc;
        valid_d  = 1'b1;
        start    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  tdc_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .reset_n(reset_n),
    .start_i(start),
    .data_i (enc),
    .tx_o   (bus.uart_tx),
    .busy_o (tx_busy)
  );

  assign bus.busy         = (state_q != IDLE) | tx_busy;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_tdc_readout.sv
// Randomized self-checking bench for tdc_readout (CLKS_PER_BIT=4).
module tb_tdc_readout;

  localparam int NS  = 10;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   fails  = 0;
  int   n_valid = 0;
  int   n_ovr   = 0;

  tdc_readout_if #(.NUM_STAGES(NS)) bus ();

  tdc_readout #(
    .NUM_STAGES  (NS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (bus.result_valid === 1'b1) n_valid++;
    if (bus.overrun === 1'b1) n_ovr++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected byte: bubble flag over the count of ones.
  function automatic logic [7:0] ref_enc(input logic [9:0] v);
    int   pc;
    logic therm;
    pc    = $countones(v);
    therm = (v == 10'((1 << pc) - 1));
    return {~therm, 7'(pc)};
  endfunction

  // One request plus a full frame; extras are injected frame cycles.
  task automatic run_frame(
    input  logic [9:0] v,
    input  int         xa,
    input  int         xb,
    input  bit         b2b,
    output logic [7:0] got
  );
    logic [7:0] exp;
    logic [9:0] bits;
    int         v0;
    int         o0;
    int         nx;
    exp = ref_enc(v);
    nx  = (xa > 0 ? 1 : 0) + (xb > 0 ? 1 : 0);
    if (!b2b) @(negedge clk);
    v0 = n_valid;
    o0 = n_ovr;
    bus.stage_delays = v;
    bus.sample_req   = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
    chk("busy_cap", bus.busy, 1);
    chk("valid_early", bus.result_valid, 0);
    @(negedge clk);
    got = bus.result;
    chk("valid", bus.result_valid, 1);
    chk("result", bus.result, exp);
    chk("tx_fall", bus.uart_tx, 0);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j % 4 == 2) bits[(j - 2) / 4] = bus.uart_tx;
      if (j == 39) chk("busy_last", bus.busy, 1);
      bus.sample_req   = (j == xa) || (j == xb);
      bus.stage_delays = 10'($urandom);
    end
    chk("busy_end", bus.busy, 0);
    chk("tx_idle", bus.uart_tx, 1);
    chk("res_hold", bus.result, exp);
    chk("start_bit", bits[0], 0);
    chk("stop_bit", bits[9], 1);
    chk("data_bits", bits[8:1], exp);
    chk("valid_cnt", n_valid - v0, 1);
    chk("ovr_cnt", n_ovr - o0, nx);
  endtask

  logic [7:0] r;
  logic [9:0] v;

  initial begin
    reset_n          = 1'b0;
    bus.sample_req   = 1'b0;
    bus.stage_delays = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("rst_idle",
          {bus.uart_tx, bus.busy, bus.result,
           bus.result_valid, bus.overrun},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    end

    run_frame(10'b0000011111, -1, -1, 0, r);
    chk("enc_therm5", r, 8'h05);
    run_frame(10'h3FF, -1, -1, 0, r);
    chk("enc_all1", r, 8'h0A);
    run_frame(10'h000, -1, -1, 0, r);
    chk("enc_all0", r, 8'h00);
    run_frame(10'b0000010111, -1, -1, 0, r);
    chk("enc_bubble", r, 8'h84);

    run_frame(10'b0001111111, 10, 39, 0, r);
    chk("enc_ovr", r, 8'h07);
    run_frame(10'b1010101010, -1, -1, 1, r);
    chk("enc_b2b", r, 8'h85);

    // Reset during DATA bit 3.
    @(negedge clk);
    bus.stage_delays = 10'h0FF;
    bus.sample_req   = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst",
        {bus.uart_tx, bus.busy, bus.result, bus.result_valid},
        {1'b1, 1'b0, 8'h00, 1'b0});
    reset_n = 1'b1;
    run_frame(10'b0000111111, -1, -1, 0, r);
    chk("enc_post_rst", r, 8'h06);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(1, 0) == 1)
        v = 10'((1 << $urandom_range(10, 0)) - 1);
      else
        v = 10'($urandom);
      run_frame(v,
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(38, 1)) : -1,
                -1, n[0], r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
